// File: rtl/handshake_bit_receiver_if.sv
// rtl/handshake_bit_receiver_if.sv - symbol handshake bundle between a bit sender and the receiver
interface handshake_bit_receiver_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W + 1);

  logic          bit1;
  logic          bit0;
  logic          dt;
  logic          ack;
  logic          senack;
  logic [W-1:0]  data;
  logic          data_valid;
  logic [CW-1:0] bit_count;
  logic          err_symbol;
  logic          err_timeout;

  modport master (
    output bit1, bit0, dt,
    input  ack, senack, data, data_valid, bit_count, err_symbol, err_timeout
  );

  modport slave (
    input  bit1, bit0, dt,
    output ack, senack, data, data_valid, bit_count, err_symbol, err_timeout
  );
endinterface

// File: rtl/handshake_bit_receiver.sv
// rtl/handshake_bit_receiver.sv - clocked receiver for the one/zero symbol handshake with word assembly
module handshake_bit_receiver #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  handshake_bit_receiver_if.slave hs
);
  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, ACK, SEN} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync1;
  logic [SYNC_STAGES-1:0] r_sync0;
  logic [SYNC_STAGES-1:0] r_syncdt;
  logic [W-1:0]           r_shift;
  logic [W-1:0]           r_data;
  logic [CW-1:0]          r_bit_count;
  logic [TW-1:0]          r_tmo;
  logic                   r_ack;
  logic                   r_senack;
  logic                   r_data_valid;
  logic                   r_err_symbol;
  logic                   r_err_timeout;
  logic                   r_sym_lock;

  logic w_s1;
  logic w_s0;
  logic w_sdt;

  assign w_s1  = r_sync1[SYNC_STAGES-1];
  assign w_s0  = r_sync0[SYNC_STAGES-1];
  assign w_sdt = r_syncdt[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_sync1       <= '0;
      r_sync0       <= '0;
      r_syncdt      <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_bit_count   <= '0;
      r_tmo         <= '0;
      r_ack         <= 1'b0;
      r_senack      <= 1'b0;
      r_data_valid  <= 1'b0;
      r_err_symbol  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_sym_lock    <= 1'b0;
    end else begin
      r_sync1       <= {r_sync1[SYNC_STAGES-2:0], hs.bit1};
      r_sync0       <= {r_sync0[SYNC_STAGES-2:0], hs.bit0};
      r_syncdt      <= {r_syncdt[SYNC_STAGES-2:0], hs.dt};
      r_data_valid  <= 1'b0;
      r_err_symbol  <= 1'b0;
      r_err_timeout <= 1'b0;
      if (!w_s1 && !w_s0) begin
        r_sym_lock <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          // After an illegal overlap, both lines must go low before any symbol counts.
          if (w_s1 && w_s0) begin
            if (!r_sym_lock) begin
              r_err_symbol <= 1'b1;
              r_sym_lock   <= 1'b1;
            end
          end else if ((w_s1 || w_s0) && !r_sym_lock) begin
            r_shift <= r_shift | (W'(w_s1) << r_bit_count);
            r_ack   <= 1'b1;
            r_state <= ACK;
          end
        end

        ACK: begin
          if (!w_s1 && !w_s0 && w_sdt) begin
            r_ack    <= 1'b0;
            r_senack <= 1'b1;
            r_tmo    <= '0;
            r_state  <= SEN;
          end else if (r_tmo == TMO_LAST) begin
            r_ack         <= 1'b0;
            r_err_timeout <= 1'b1;
            r_bit_count   <= '0;
            r_shift       <= '0;
            r_tmo         <= '0;
            r_state       <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        SEN: begin
          if (!w_sdt) begin
            r_senack <= 1'b0;
            r_tmo    <= '0;
            r_state  <= IDLE;
            if (r_bit_count == CNT_LAST) begin
              r_data       <= r_shift;
              r_data_valid <= 1'b1;
              r_bit_count  <= '0;
              r_shift      <= '0;
            end else begin
              r_bit_count <= r_bit_count + 1'b1;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_senack      <= 1'b0;
            r_err_timeout <= 1'b1;
            r_bit_count   <= '0;
            r_shift       <= '0;
            r_tmo         <= '0;
            r_state       <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        default: begin
          r_ack    <= 1'b0;
          r_senack <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign hs.ack         = r_ack;
  assign hs.senack      = r_senack;
  assign hs.data        = r_data;
  assign hs.data_valid  = r_data_valid;
  assign hs.bit_count   = r_bit_count;
  assign hs.err_symbol  = r_err_symbol;
  assign hs.err_timeout = r_err_timeout;
endmodule

// File: tb/tb_handshake_bit_receiver.sv
// tb/tb_handshake_bit_receiver.sv - directed and randomized bench for handshake_bit_receiver
module tb_handshake_bit_receiver;
  localparam int W  = 8;
  localparam int TO = 20;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  handshake_bit_receiver_if #(.W(W)) hs ();

  handshake_bit_receiver #(
    .W(W),
    .SYNC_STAGES(2),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hs   (hs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] got_q[$];
  int n_valid;
  int n_err_sym;
  int n_err_tmo;
  int n_overlap;
  int valid_cyc;
  int dt_fall_cyc;
  int ack_cyc;

  initial begin
    n_valid = 0; n_err_sym = 0; n_err_tmo = 0; n_overlap = 0; valid_cyc = 0;
  end

  always @(negedge clk) begin
    if (hs.data_valid) begin
      got_q.push_back(hs.data);
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (hs.err_symbol)  n_err_sym = n_err_sym + 1;
    if (hs.err_timeout) n_err_tmo = n_err_tmo + 1;
    if (hs.ack && hs.senack) n_overlap = n_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel: 0 ack, 1 senack, 2 err_timeout
  task automatic wait_for(input int sel, input logic val, input int limit, input string tag);
    logic hit;
    logic cur;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       cur = hs.ack;
        1:       cur = hs.senack;
        default: cur = hs.err_timeout;
      endcase
      if (cur === val) hit = 1'b1;
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_sym(input bit b);
    @(negedge clk);
    hs.bit1 = b;
    hs.bit0 = !b;
    wait_for(0, 1'b1, 40, "ack_rise");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    hs.bit1 = 1'b0;
    hs.bit0 = 1'b0;
    hs.dt   = 1'b1;
    wait_for(1, 1'b1, 40, "senack_rise");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    hs.dt       = 1'b0;
    dt_fall_cyc = cyc;
    wait_for(1, 1'b0, 40, "senack_fall");
  endtask

  // Reference: symbol i carries weight 2**i in the assembled word.
  task automatic send_bits(input bit bits[W], output logic [W-1:0] word);
    int acc;
    acc = 0;
    for (int i = 0; i < W; i++) begin
      send_sym(bits[i]);
      acc = acc + (bits[i] ? (1 << i) : 0);
    end
    word = W'(acc);
  endtask

  task automatic send_value(input logic [W-1:0] v, output logic [W-1:0] word);
    bit bits[W];
    for (int i = 0; i < W; i++) bits[i] = ((v >> i) & 1) != 0;
    send_bits(bits, word);
  endtask

  task automatic expect_word(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] g;
    repeat (2) @(negedge clk);
    check({tag, "_count"}, 32'(got_q.size()), 32'd1);
    g = (got_q.size() > 0) ? got_q.pop_front() : '0;
    check({tag, "_data"}, 32'(g), 32'(exp));
    got_q.delete();
  endtask

  logic [W-1:0] model_word;
  logic [W-1:0] last_word;
  int           nv0;
  int           ne0;
  bit           pat[W];

  initial begin
    total = 0; bad = 0;
    hs.bit1 = 1'b1; hs.bit0 = 1'b0; hs.dt = 1'b0;
    reset = 1'b0;

    // reset with a symbol already pending
    repeat (4) @(negedge clk);
    check("rst_ack", 32'(hs.ack), 32'd0);
    check("rst_senack", 32'(hs.senack), 32'd0);
    check("rst_data", 32'(hs.data), 32'd0);
    check("rst_bit_count", 32'(hs.bit_count), 32'd0);
    check("rst_valid", 32'(hs.data_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk); check("rel_ack_c1", 32'(hs.ack), 32'd0);
    @(negedge clk); check("rel_ack_c2", 32'(hs.ack), 32'd0);
    @(negedge clk); check("rel_ack_c3", 32'(hs.ack), 32'd1);
    hs.bit1 = 1'b0; hs.dt = 1'b1;
    wait_for(1, 1'b1, 40, "t1_senack_rise");
    hs.dt = 1'b0;
    wait_for(1, 1'b0, 40, "t1_senack_fall");
    check("t1_bit_count", 32'(hs.bit_count), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got_q.delete();

    // single word 1,0,1,1,0,0,1,0
    pat = '{1, 0, 1, 1, 0, 0, 1, 0};
    send_bits(pat, model_word);
    check("t2_model", 32'(model_word), 32'h4D);
    @(negedge clk);
    check("t2_valid_latency", 32'(valid_cyc - dt_fall_cyc), 32'd3);
    check("t2_bit_count", 32'(hs.bit_count), 32'd0);
    expect_word("t2", model_word);

    // back-to-back words, then random ones
    send_value(8'hA5, model_word);
    expect_word("t3_a5", 8'hA5);
    send_value(8'h3C, model_word);
    expect_word("t3_3c", 8'h3C);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) pat[i] = bit'($urandom_range(0, 1));
      send_bits(pat, model_word);
      expect_word("t3_rand", model_word);
    end
    last_word = model_word;

    // illegal symbol overlap
    ne0 = n_err_sym;
    @(negedge clk);
    hs.bit1 = 1'b1; hs.bit0 = 1'b1;
    begin
      int ack_seen;
      ack_seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (hs.ack) ack_seen = ack_seen + 1;
      end
      check("t4_no_ack", 32'(ack_seen), 32'd0);
    end
    hs.bit1 = 1'b0; hs.bit0 = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_err_pulses", 32'(n_err_sym - ne0), 32'd1);
    send_sym(1'b1);
    @(negedge clk);
    check("t4_bit_count", 32'(hs.bit_count), 32'd1);

    // stall after the 4th symbol's ack
    send_sym(bit'($urandom_range(0, 1)));
    send_sym(bit'($urandom_range(0, 1)));
    @(negedge clk);
    hs.bit1 = 1'b1;
    wait_for(0, 1'b1, 40, "t5_ack_rise");
    ack_cyc = cyc;
    hs.bit1 = 1'b0;
    wait_for(2, 1'b1, 60, "t5_err_timeout");
    check("t5_tmo_latency", 32'(cyc - ack_cyc), 32'(TO));
    check("t5_ack_low", 32'(hs.ack), 32'd0);
    check("t5_bit_count", 32'(hs.bit_count), 32'd0);
    check("t5_data_held", 32'(hs.data), 32'(last_word));
    repeat (3) @(negedge clk);
    got_q.delete();
    send_value(W'($urandom), model_word);
    expect_word("t5_recover", model_word);

    // reset while in SEN after 5 bits
    for (int i = 0; i < 5; i++) send_sym(bit'($urandom_range(0, 1)));
    @(negedge clk);
    hs.bit0 = 1'b1;
    wait_for(0, 1'b1, 40, "t6_ack_rise");
    hs.bit0 = 1'b0; hs.dt = 1'b1;
    wait_for(1, 1'b1, 40, "t6_senack_rise");
    reset = 1'b0;
    @(negedge clk);
    check("t6_senack_drop", 32'(hs.senack), 32'd0);
    hs.dt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    got_q.delete();
    nv0 = n_valid;
    for (int i = 0; i < W; i++) pat[i] = bit'($urandom_range(0, 1));
    send_bits(pat, model_word);
    repeat (3) @(negedge clk);
    check("t6_one_valid", 32'(n_valid - nv0), 32'd1);
    check("t6_data", 32'(hs.data), 32'(model_word));

    check("ack_senack_overlap", 32'(n_overlap), 32'd0);
    check("err_timeout_total", 32'(n_err_tmo), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
